if_id_register: RTL and testbench

//  Pipeline register between instruction fetch (IF) and decode (ID) in the 5-stage RV32I CPU.

---
 rtl/if_id_register.sv | 93 +++++++++
 tb/tb_if_id_register.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall hold, flush-to-NOP bubble and an occupancy state machine.
// Optional stall/flush performance counters are built only when IF_ID_PERF_EN is defined.
module if_id_register #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [31:0]      instr_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_VALID  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_BUBBLE = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;

  // Flush beats stall; a stall only changes state when it freezes a real instruction.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = S_BUBBLE;
    end else if (stall_i) begin
      if (state == S_VALID || state == S_HOLD) state_next = S_HOLD;
    end else begin
      state_next = S_VALID;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_EMPTY;
      pc_o     <= '0;
      instr_o  <= NOP_INSTR;
      bubble_o <= 1'b0;
    end else begin
      state <= state_next;
      if (flush_i) begin
        pc_o     <= pc_i;
        instr_o  <= NOP_INSTR;
        bubble_o <= 1'b1;
      end else if (stall_i) begin
        bubble_o <= 1'b0;
      end else begin
        pc_o     <= pc_i;
        instr_o  <= instr_i;
        bubble_o <= 1'b0;
      end
    end
  end

  assign valid_o = (state == S_VALID) || (state == S_HOLD);
  assign state_o = state;

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush_i) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (stall_i) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Bench for if_id_register: directed scenarios plus random stall/flush/reset traffic
// checked every cycle against a behavioural model of the pipeline register.
module tb_if_id_register;

  localparam int          XLEN = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] NOP  = 32'h00000013;
`ifdef IF_ID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int MODEL_EMPTY = 0, MODEL_VALID = 1, MODEL_HOLD = 2, MODEL_BUBBLE = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [XLEN-1:0]  pc_i = '0;
  logic [31:0]      instr_i = '0;
  logic             stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [XLEN-1:0]  pc_o;
  logic [31:0]      instr_o;
  logic             valid_o;
  logic             bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [1:0]       state_o;

  int total = 0;
  int bad = 0;

  // behavioural model
  logic [31:0] m_pc, m_instr;
  bit          m_valid, m_bubble;
  int          m_state, m_sc, m_fc;

  always #5 clk = ~clk;

  if_id_register #(.XLEN(XLEN), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
    .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc_o), .instr_o(instr_o),
    .valid_o(valid_o), .bubble_o(bubble_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit f,
                            input logic [31:0] p, input logic [31:0] ins);
    if (r) begin
      m_pc = 0; m_instr = NOP; m_valid = 0; m_bubble = 0;
      m_state = MODEL_EMPTY; m_sc = 0; m_fc = 0;
    end else if (f) begin
      m_pc = p; m_instr = NOP; m_valid = 0; m_bubble = 1;
      m_state = MODEL_BUBBLE;
      if (PERF && m_fc < CNT_MAX) m_fc++;
    end else if (s) begin
      m_bubble = 0;
      if (m_state == MODEL_VALID) m_state = MODEL_HOLD;
      if (PERF && m_sc < CNT_MAX) m_sc++;
    end else begin
      m_pc = p; m_instr = ins; m_valid = 1; m_bubble = 0;
      m_state = MODEL_VALID;
    end
  endtask

  task automatic check_all();
    check("pc", 64'(pc_o), 64'(m_pc));
    check("instr", 64'(instr_o), 64'(m_instr));
    check("valid", 64'(valid_o), 64'(m_valid));
    check("bubble", 64'(bubble_o), 64'(m_bubble));
    check("state", 64'(state_o), 64'(m_state));
    check("stall_cnt", 64'(stall_cnt_o), 64'(m_sc));
    check("flush_cnt", 64'(flush_cnt_o), 64'(m_fc));
  endtask

  task automatic cycle(input bit r, input bit s, input bit f,
                       input logic [31:0] p, input logic [31:0] ins);
    rst_i = r; stall_i = s; flush_i = f; pc_i = p; instr_i = ins;
    @(posedge clk);
    model_edge(r, s, f, p, ins);
    #1;
    check_all();
  endtask

  initial begin
    // 1: reset for two clocks
    cycle(1, 0, 0, 32'h1234, 32'hdead_beef);
    cycle(1, 1, 1, 32'h5678, 32'hcafe_f00d);
    check("t1_pc", 64'(pc_o), 64'h0);
    check("t1_instr", 64'(instr_o), 64'h13);
    check("t1_valid", 64'(valid_o), 64'h0);

    // 2: normal flow
    cycle(0, 0, 0, 32'h04, 32'h00500093);
    check("t2_pc", 64'(pc_o), 64'h04);
    check("t2_instr", 64'(instr_o), 64'h00500093);
    check("t2_valid", 64'(valid_o), 64'h1);

    // 3: load then stall three cycles with changing inputs
    cycle(0, 0, 0, 32'h08, 32'h002081B3);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 32'h100 + 32'(i * 4), $urandom);
      check("t3_pc", 64'(pc_o), 64'h08);
      check("t3_instr", 64'(instr_o), 64'h002081B3);
      check("t3_valid", 64'(valid_o), 64'h1);
    end

    // 4: flush and stall together, then a normal cycle
    cycle(0, 1, 1, 32'h0C, 32'h00A00113);
    check("t4_instr", 64'(instr_o), 64'h13);
    check("t4_pc", 64'(pc_o), 64'h0C);
    check("t4_valid", 64'(valid_o), 64'h0);
    check("t4_bubble", 64'(bubble_o), 64'h1);
    cycle(0, 1, 0, 32'h10, 32'h00B00193);
    check("t4_bubble_held", 64'(bubble_o), 64'h0);
    check("t4_held_valid", 64'(valid_o), 64'h0);
    cycle(0, 0, 0, 32'h10, 32'h00B00193);
    check("t4_bubble_clear", 64'(bubble_o), 64'h0);

    // 5: reset while stalling
    cycle(0, 1, 0, 32'h14, 32'h0);
    cycle(1, 1, 0, 32'h18, 32'hffff_ffff);
    check("t5_state", 64'(state_o), 64'(MODEL_EMPTY));
    check("t5_instr", 64'(instr_o), 64'h13);

    // 6: counter accumulation
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, $urandom, $urandom);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, $urandom, $urandom);
    check("t6_stall_cnt", 64'(stall_cnt_o), PERF ? 64'd5 : 64'd0);
    check("t6_flush_cnt", 64'(flush_cnt_o), PERF ? 64'd2 : 64'd0);

    // random traffic, including malformed opcodes passed through
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom, $urandom);
    end

    // saturation: drive counters past all-ones
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 3; i++) cycle(0, 1, 0, $urandom, $urandom);
    check("sat_stall_cnt", 64'(stall_cnt_o), PERF ? 64'(CNT_MAX) : 64'd0);
    cycle(0, 0, 1, 32'h40, 32'h0);
    check("sat_stall_after_flush", 64'(stall_cnt_o), PERF ? 64'(CNT_MAX) : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
